fifo_rr_drain_arb: RTL and testbench

//   Round-robin drain scheduler that shares one output stream among N source FIFOs.

---
 rtl/fifo_rr_drain_arb_pkg.sv | 18 +
 rtl/fifo_rr_drain_arb_if.sv | 26 ++
 rtl/fifo_rr_drain_arb_pick.sv | 29 ++
 rtl/fifo_rr_drain_arb.sv | 117 +++++++++++
 tb/tb_fifo_rr_drain_arb.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_drain_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO drain arbiter.
package fifo_rr_drain_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam int N_SRC_DEF      = 4;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int BURST_DEF      = 4;

   // Source index width; a single source would still need one bit.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rr_drain_arb_if.sv
// Source-FIFO side and output stream of the drain arbiter.
interface fifo_rr_drain_arb_if
   import fifo_rr_drain_arb_pkg::*;
#(
   parameter int N_SRC      = N_SRC_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int SRC_W      = src_w(N_SRC)
);
   logic [N_SRC-1:0]            src_empty;
   logic [N_SRC*DATA_WIDTH-1:0] src_data;
   logic [N_SRC-1:0]            src_rd_en;
   logic                        out_valid;
   logic                        out_ready;
   logic [DATA_WIDTH-1:0]       out_data;
   logic [SRC_W-1:0]            out_src;

   modport master (
      input  src_empty, src_data, out_ready,
      output src_rd_en, out_valid, out_data, out_src
   );

   modport slave (
      output src_empty, src_data, out_ready,
      input  src_rd_en, out_valid, out_data, out_src
   );
endinterface

// File: rtl/fifo_rr_drain_arb_pick.sv
// Rotating-priority encoder: first set req bit at or after base, wrapping at N_SRC.
module fifo_rr_pick
   import fifo_rr_drain_arb_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF,
   parameter int SRC_W = src_w(N_SRC)
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [SRC_W-1:0] base_i,
   output logic             any_o,
   output logic [SRC_W-1:0] idx_o
);

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      int               c;
      logic [SRC_W-1:0] ci;
      idx_o = base_i;
      for (int off = N_SRC - 1; off >= 0; off--) begin
         c = int'(base_i) + off;
         if (c >= N_SRC) c = c - N_SRC;
         ci = SRC_W'(c);
         if (req_i[ci]) idx_o = ci;
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain of N show-ahead FIFOs into one valid/ready stream,
// up to BURST words per grant with one idle cycle between grants.
module fifo_rr_drain_arb
   import fifo_rr_drain_arb_pkg::*;
#(
   parameter int N_SRC      = N_SRC_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BURST      = BURST_DEF,
   parameter int SRC_W      = src_w(N_SRC)
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_rr_drain_arb_if.master  bus,
   output logic                 busy
);

   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

   arb_state_e            state_q, state_d;
   logic [SRC_W-1:0]      cur_q, cur_d;
   logic [SRC_W-1:0]      rr_q, rr_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [SRC_W-1:0]      out_src_q;

   logic [DATA_WIDTH-1:0] word [N_SRC];
   logic                  pick_any;
   logic [SRC_W-1:0]      pick_idx;
   logic                  cur_empty, pop, last_beat;
   logic [SRC_W-1:0]      cur_nxt;

   for (genvar g = 0; g < N_SRC; g++) begin : g_word
      assign word[g] = bus.src_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   fifo_rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_pick (
      .req_i  (~bus.src_empty),
      .base_i (rr_q),
      .any_o  (pick_any),
      .idx_o  (pick_idx)
   );

   assign cur_empty = bus.src_empty[cur_q];
   assign pop       = (state_q == ARB_GRANT) && !cur_empty && (!out_valid_q || bus.out_ready);
   assign last_beat = (beat_q == BW'(BURST - 1));
   assign cur_nxt   = (cur_q == SRC_W'(N_SRC - 1)) ? '0 : cur_q + SRC_W'(1);

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               cur_d   = pick_idx;
               beat_d  = '0;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            // Stalled by backpressure: neither branch fires, grant is held.
            if (pop) begin
               beat_d = beat_q + BW'(1);
               if (last_beat) begin
                  state_d = ARB_IDLE;
                  rr_d    = cur_nxt;
               end
            end else if (cur_empty) begin
               state_d = ARB_IDLE;
               rr_d    = cur_nxt;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      bus.src_rd_en = '0;
      if (pop) bus.src_rd_en[cur_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         cur_q   <= '0;
         rr_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rr_q    <= rr_d;
         beat_q  <= beat_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         out_data_q  <= word[cur_q];
         out_src_q   <= cur_q;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign busy          = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Bench for fifo_rr_drain_arb: behavioural 16-deep show-ahead source FIFOs,
// directed scenarios plus a randomized run against a per-source order scoreboard.
module tb_fifo_rr_drain_arb;
   import fifo_rr_drain_arb_pkg::*;

   localparam int NS    = 4;
   localparam int DW    = 8;
   localparam int BURST = 4;
   localparam int SW    = 2;
   localparam int DEPTH = 16;

   typedef struct {
      int src;
      int data;
      int cyc;
   } rec_t;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   fifo_rr_drain_arb_if #(.N_SRC(NS), .DATA_WIDTH(DW), .SRC_W(SW)) bus_if ();

   fifo_rr_drain_arb #(.N_SRC(NS), .DATA_WIDTH(DW), .BURST(BURST), .SRC_W(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fq    [NS][$];
   logic [DW-1:0] exp_q [NS][$];
   logic [NS-1:0] push_en;
   logic [DW-1:0] push_dat [NS];
   logic          flush;
   int            cyc = 0;
   rec_t          got[$];
   int            rd_viol = 0;
   int            grant_viol = 0;
   int            pops_in_grant = 0;
   int            grant_src = -1;
   int            n_tests = 0;
   int            n_fail = 0;

   // Source FIFOs: pop on read_en, push on request, flags/data registered.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NS; i++) begin
         if (flush) begin
            fq[i].delete();
            exp_q[i].delete();
         end else begin
            if (bus_if.src_rd_en[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            if (push_en[i] && fq[i].size() < DEPTH) begin
               fq[i].push_back(push_dat[i]);
               exp_q[i].push_back(push_dat[i]);
            end
         end
      end
      for (int i = 0; i < NS; i++) begin
         bus_if.src_empty[i]          <= (fq[i].size() == 0);
         bus_if.src_data[i*DW +: DW] <= (fq[i].size() > 0) ? fq[i][0] : '0;
      end
   end

   // Capture accepted words and track per-grant pop behaviour.
   always @(negedge clk) begin
      int s;
      if (!reset) begin
         if (bus_if.out_valid && bus_if.out_ready)
            got.push_back('{int'(bus_if.out_src), int'(bus_if.out_data), cyc});
         if ($countones(bus_if.src_rd_en) > 1) rd_viol++;
         if (bus_if.src_rd_en != '0 && !busy) rd_viol++;
         if (!busy) begin
            pops_in_grant = 0;
            grant_src     = -1;
         end else if (bus_if.src_rd_en != '0) begin
            s = 0;
            for (int i = 0; i < NS; i++) if (bus_if.src_rd_en[i]) s = i;
            if (grant_src >= 0 && s != grant_src) grant_viol++;
            grant_src = s;
            pops_in_grant++;
            if (pops_in_grant > BURST) grant_viol++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      push_en          = '0;
      bus_if.out_ready = 1'b1;
      flush            = 1'b1;
      step();
      flush = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_words(input int base, input int n, input int budget, output bit timed_out);
      int k = 0;
      while (got.size() < base + n && k < budget) begin
         step();
         k++;
      end
      timed_out = (got.size() < base + n);
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      push_en          = '0;
      bus_if.out_ready = 1'b1;
      flush            = 1'b1;
      step();
      flush = 1'b0;
      step();
      n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.out_valid); end
      n_tests++; if (bus_if.src_rd_en !== 4'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0000", bus_if.src_rd_en); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (bus_if.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus_if.out_data); end
      n_tests++; if (bus_if.out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus_if.out_src); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_src();
      int base, t_e, t_rd, t_v;
      bit to;
      do_reset();
      base = got.size();
      t_e = -1; t_rd = -1; t_v = -1;
      for (int k = 0; k < 12; k++) begin
         push_en     = (k < 3) ? 4'b0001 : 4'b0000;
         push_dat[0] = 8'hA0 + 8'(k);
         @(negedge clk);
         if (t_e < 0 && !bus_if.src_empty[0]) t_e = k;
         if (t_rd < 0 && bus_if.src_rd_en[0]) t_rd = k;
         if (t_v < 0 && bus_if.out_valid) t_v = k;
         @(posedge clk);
         #1;
      end
      push_en = '0;
      to = (got.size() < base + 3);
      n_tests++; if (to) begin n_fail++; $display("FAIL single_timeout: got %0d words want 3", got.size() - base); end
      n_tests++; if (t_rd - t_e !== 1) begin n_fail++; $display("FAIL single_rd_latency: got %0d want 1", t_rd - t_e); end
      n_tests++; if (t_v - t_e !== 2) begin n_fail++; $display("FAIL single_valid_latency: got %0d want 2", t_v - t_e); end
      if (!to) begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (got[base+i].data !== 32'hA0 + i || got[base+i].src !== 0) begin
               n_fail++;
               $display("FAIL single_word%0d: got src%0d/%h want src0/%h", i, got[base+i].src, got[base+i].data, 8'hA0 + i);
            end
         end
         n_tests++; if (got[base+2].cyc - got[base].cyc !== 2) begin n_fail++; $display("FAIL single_back_to_back: span %0d want 2", got[base+2].cyc - got[base].cyc); end
      end
      // Pointer moved past src0: with src0 and src1 both ready, src1 goes first.
      push_en = 4'b0011; push_dat[0] = 8'hB0; push_dat[1] = 8'hB1;
      step();
      push_en = '0;
      wait_words(base + 3, 2, 20, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL single_rr_timeout: got %0d words want 5", got.size() - base); end
      if (!to) begin
         n_tests++;
         if (got[base+3].src !== 1 || got[base+4].src !== 0) begin
            n_fail++;
            $display("FAIL single_rr_ptr: got src%0d,src%0d want src1,src0", got[base+3].src, got[base+4].src);
         end
      end
   endtask

   task automatic test_all_sources();
      int  base, es, ed, gap;
      bit  to;
      do_reset();
      base = got.size();
      for (int k = 0; k < 8; k++) begin
         push_en = '1;
         for (int i = 0; i < NS; i++) push_dat[i] = 8'(i * 16 + k);
         step();
      end
      push_en = '0;
      wait_words(base, 32, 200, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL all_timeout: got %0d words want 32", got.size() - base); end
      if (!to) begin
         for (int j = 0; j < 32; j++) begin
            es = (j / 4) % 4;
            ed = es * 16 + (j / 16) * 4 + (j % 4);
            n_tests++;
            if (got[base+j].src !== es || got[base+j].data !== ed) begin
               n_fail++;
               $display("FAIL all_word%0d: got src%0d/%h want src%0d/%h", j, got[base+j].src, got[base+j].data, es, ed);
            end
            if (j > 0) begin
               gap = (j % 4 == 0) ? 2 : 1;
               n_tests++;
               if (got[base+j].cyc - got[base+j-1].cyc !== gap) begin
                  n_fail++;
                  $display("FAIL all_gap%0d: got %0d want %0d", j, got[base+j].cyc - got[base+j-1].cyc, gap);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      bit to, bad;
      do_reset();
      bus_if.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_en = 4'b0001; push_dat[0] = 8'hC0 + 8'(k);
         step();
      end
      push_en = '0;
      step(); step();
      base = got.size();
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus_if.src_rd_en !== 4'b0 || bus_if.out_data !== 8'hC1 || bus_if.out_valid !== 1'b1) begin
            bad = 1'b1;
            $display("FAIL bp_stall cyc%0d: rd_en=%b data=%h valid=%b want 0000/c1/1", k, bus_if.src_rd_en, bus_if.out_data, bus_if.out_valid);
         end
         @(posedge clk);
         #1;
      end
      n_tests++; if (bad) n_fail++;
      bus_if.out_ready = 1'b1;
      wait_words(base, 4, 20, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 4", got.size() - base); end
      if (!to) begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[base+i].data !== 32'hC0 + i || got[base+i].src !== 0) begin
               n_fail++;
               $display("FAIL bp_word%0d: got src%0d/%h want src0/%h", i, got[base+i].src, got[base+i].data, 8'hC0 + i);
            end
         end
         n_tests++; if (got[base+1].cyc - got[base].cyc !== 6) begin n_fail++; $display("FAIL bp_hold_len: got %0d want 6", got[base+1].cyc - got[base].cyc); end
         n_tests++; if (got[base+3].cyc - got[base+1].cyc !== 2) begin n_fail++; $display("FAIL bp_resume: got %0d want 2", got[base+3].cyc - got[base+1].cyc); end
      end
   endtask

   task automatic test_drain_exit();
      int base;
      int es[6] = '{1, 1, 2, 2, 2, 2};
      int ed[6] = '{'h10, 'h11, 'h20, 'h21, 'h22, 'h23};
      bit to;
      do_reset();
      base = got.size();
      for (int k = 0; k < 4; k++) begin
         push_en = (k < 2) ? 4'b0110 : 4'b0100;
         push_dat[1] = 8'h10 + 8'(k);
         push_dat[2] = 8'h20 + 8'(k);
         step();
      end
      push_en = '0;
      wait_words(base, 6, 40, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL drain_timeout: got %0d words want 6", got.size() - base); end
      if (!to) begin
         for (int j = 0; j < 6; j++) begin
            n_tests++;
            if (got[base+j].src !== es[j] || got[base+j].data !== ed[j]) begin
               n_fail++;
               $display("FAIL drain_word%0d: got src%0d/%h want src%0d/%h", j, got[base+j].src, got[base+j].data, es[j], ed[j]);
            end
         end
         n_tests++; if (got[base+2].cyc - got[base+1].cyc !== 3) begin n_fail++; $display("FAIL drain_switch_gap: got %0d want 3", got[base+2].cyc - got[base+1].cyc); end
      end
   endtask

   task automatic test_wrap();
      int base;
      int es[4] = '{3, 3, 0, 0};
      int ed[4] = '{'h3A, 'h3B, 'h0A, 'h0B};
      bit to;
      do_reset();
      base = got.size();
      push_en = 4'b0100; push_dat[2] = 8'h2F;
      step();
      push_en = '0;
      wait_words(base, 1, 20, to);
      step(); step(); step();
      base = got.size();
      for (int k = 0; k < 2; k++) begin
         push_en = 4'b1001;
         push_dat[0] = 8'h0A + 8'(k);
         push_dat[3] = 8'h3A + 8'(k);
         step();
      end
      push_en = '0;
      wait_words(base, 4, 30, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL wrap_timeout: got %0d words want 4", got.size() - base); end
      if (!to) begin
         for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (got[base+j].src !== es[j] || got[base+j].data !== ed[j]) begin
               n_fail++;
               $display("FAIL wrap_word%0d: got src%0d/%h want src%0d/%h", j, got[base+j].src, got[base+j].data, es[j], ed[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      bit to;
      do_reset();
      base = got.size();
      push_en = 4'b0100; push_dat[2] = 8'h2F;
      step();
      push_en = '0;
      wait_words(base, 1, 20, to);
      step(); step(); step();
      bus_if.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         push_en = (k < 3) ? 4'b1010 : 4'b1000;
         push_dat[1] = 8'h10 + 8'(k);
         push_dat[3] = 8'h30 + 8'(k);
         step();
      end
      push_en = '0;
      bus_if.out_ready = 1'b1;
      step(); step();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
      reset = 1'b1;
      #1;
      n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus_if.out_valid); end
      n_tests++; if (bus_if.src_rd_en !== 4'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b want 0000", bus_if.src_rd_en); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      step(); step();
      reset = 1'b0;
      base = got.size();
      wait_words(base, 1, 20, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: no word after release"); end
      if (!to) begin
         n_tests++;
         if (got[base].src !== 1 || got[base].data !== 'h10) begin
            n_fail++;
            $display("FAIL rstmid_first: got src%0d/%h want src1/10", got[base].src, got[base].data);
         end
      end
   endtask

   task automatic test_random();
      int base, total, rd0, gv0, ix;
      int idx[NS];
      bit bad;
      do_reset();
      base = got.size();
      rd0  = rd_viol;
      gv0  = grant_viol;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < NS; i++) begin
            push_en[i]  = ($urandom_range(0, 99) < 30) && (fq[i].size() < DEPTH);
            push_dat[i] = 8'($urandom);
         end
         bus_if.out_ready = ($urandom_range(0, 99) < 70);
         step();
      end
      push_en = '0;
      bus_if.out_ready = 1'b1;
      step();
      total = 0;
      for (int i = 0; i < NS; i++) total += exp_q[i].size();
      for (int k = 0; k < 400 && got.size() < base + total; k++) step();
      step(); step(); step();
      n_tests++; if (got.size() - base !== total) begin n_fail++; $display("FAIL rand_count: got %0d words want %0d", got.size() - base, total); end
      for (int i = 0; i < NS; i++) idx[i] = 0;
      bad = 1'b0;
      for (int j = base; j < got.size(); j++) begin
         ix = got[j].src;
         if (ix < 0 || ix >= NS || idx[ix] >= exp_q[ix].size()) begin
            bad = 1'b1;
            $display("FAIL rand_extra: word %0d from src%0d not expected", j - base, ix);
         end else begin
            if (got[j].data !== int'(exp_q[ix][idx[ix]])) begin
               bad = 1'b1;
               $display("FAIL rand_order: src%0d word %0d got %h want %h", ix, idx[ix], got[j].data, exp_q[ix][idx[ix]]);
            end
            idx[ix]++;
         end
      end
      n_tests++; if (bad) n_fail++;
      n_tests++; if (rd_viol - rd0 !== 0) begin n_fail++; $display("FAIL rand_rd_en: %0d bad read enables want 0", rd_viol - rd0); end
      n_tests++; if (grant_viol - gv0 !== 0) begin n_fail++; $display("FAIL rand_grant: %0d grant violations want 0", grant_viol - gv0); end
      n_tests++; if (busy !== 1'b0 || bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle: busy=%b valid=%b want 0/0", busy, bus_if.out_valid); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b0;
      flush            = 1'b0;
      push_en          = '0;
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < NS; i++) push_dat[i] = '0;
      #1;
      test_reset();
      test_single_src();
      test_all_sources();
      test_backpressure();
      test_drain_exit();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
